// File: rtl/snax_csr_mux_translator.sv
// Round-robin mux of NumPorts Snitch accelerator request channels onto one CSR port.
// Read responses are routed back in order through an outstanding-read tracking FIFO.
module snax_csr_mux_translator #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned NumOutstanding = 4,
  parameter logic [31:0] CsrAddrOffset  = 32'h3c0,
  parameter int unsigned NumCsr         = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts*32-1:0]          snax_req_data_op_i,
  input  logic [NumPorts*DataWidth-1:0]   snax_req_data_arga_i,
  input  logic [NumPorts*32-1:0]          snax_req_data_argb_i,
  input  logic [NumPorts*IdWidth-1:0]     snax_req_id_i,
  input  logic [NumPorts-1:0]             snax_qvalid_i,
  output logic [NumPorts-1:0]             snax_qready_o,
  output logic [NumPorts*DataWidth-1:0]   snax_rsp_data_o,
  output logic [NumPorts*IdWidth-1:0]     snax_rsp_id_o,
  output logic [NumPorts-1:0]             snax_rsp_error_o,
  output logic [NumPorts-1:0]             snax_pvalid_o,
  input  logic [NumPorts-1:0]             snax_pready_i,
  output logic [DataWidth-1:0]            snax_csr_req_bits_data_o,
  output logic [AddrWidth-1:0]            snax_csr_req_bits_addr_o,
  output logic                            snax_csr_req_bits_write_o,
  output logic                            snax_csr_req_valid_o,
  input  logic                            snax_csr_req_ready_i,
  input  logic [DataWidth-1:0]            snax_csr_rsp_bits_data_i,
  input  logic                            snax_csr_rsp_valid_i,
  output logic                            snax_csr_rsp_ready_o,
  output logic [$clog2(NumOutstanding):0] outstanding_o,
  output logic                            proto_err_o
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW  = $clog2(NumOutstanding);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic {ArbFree, ArbLocked} arb_state_e;

  arb_state_e       arb_q;
  logic [PortW-1:0] lock_port_q;
  logic [PortW-1:0] rr_q;
  logic [PortW-1:0] grant;
  logic [PortW-1:0] cand;
  logic             any_req;

  logic [PortW-1:0]   fifo_port_q [NumOutstanding];
  logic [IdWidth-1:0] fifo_id_q   [NumOutstanding];
  logic               fifo_err_q  [NumOutstanding];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               proto_err_q;
  logic               full, empty;

  logic [31:0]          op_g, argb_g, csr_idx;
  logic [DataWidth-1:0] arga_g;
  logic [IdWidth-1:0]   id_g;
  logic                 is_read, in_range, q_fire, push, pop;
  logic                 unused_op_bits;

  logic [PortW-1:0]     head_port;
  logic [IdWidth-1:0]   head_id;
  logic                 head_err;
  logic [DataWidth-1:0] rsp_data;

  assign full  = (count_q == CntW'(NumOutstanding));
  assign empty = (count_q == '0);

  // A request stalled on csr_req_ready keeps the grant so its CSR fields stay stable.
  always_comb begin
    grant   = lock_port_q;
    any_req = 1'b0;
    cand    = '0;
    if (arb_q == ArbLocked) begin
      any_req = snax_qvalid_i[lock_port_q];
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (32'(rr_q) + i >= NumPorts) cand = PortW'(32'(rr_q) + i - NumPorts);
        else                            cand = PortW'(32'(rr_q) + i);
        if (!any_req && snax_qvalid_i[cand]) begin
          any_req = 1'b1;
          grant   = cand;
        end
      end
    end
  end

  assign op_g    = snax_req_data_op_i[grant*32 +: 32];
  assign argb_g  = snax_req_data_argb_i[grant*32 +: 32];
  assign arga_g  = snax_req_data_arga_i[grant*DataWidth +: DataWidth];
  assign id_g    = snax_req_id_i[grant*IdWidth +: IdWidth];
  assign csr_idx = argb_g - CsrAddrOffset;

  // SYSTEM opcode with funct3[1] set covers exactly CSRRS/CSRRC/CSRRSI/CSRRCI.
  assign is_read        = (op_g[6:0] == 7'h73) && op_g[13];
  assign in_range       = (argb_g >= CsrAddrOffset) && (csr_idx < NumCsr);
  assign unused_op_bits = ^{op_g[31:14], op_g[12:7]};

  always_comb begin
    snax_csr_req_valid_o = 1'b0;
    q_fire               = 1'b0;
    snax_qready_o        = '0;
    if (!rst_i && any_req) begin
      if (in_range) begin
        snax_csr_req_valid_o = !is_read || !full;
        q_fire               = snax_csr_req_valid_o && snax_csr_req_ready_i;
      end else begin
        q_fire = !is_read || !full;
      end
      snax_qready_o[grant] = q_fire;
    end
  end

  assign push = q_fire && is_read;

  assign snax_csr_req_bits_data_o  = arga_g;
  assign snax_csr_req_bits_addr_o  = AddrWidth'(csr_idx);
  assign snax_csr_req_bits_write_o = !is_read;

  assign head_port = fifo_port_q[rd_ptr_q];
  assign head_id   = fifo_id_q[rd_ptr_q];
  assign head_err  = fifo_err_q[rd_ptr_q];
  assign rsp_data  = head_err ? '0 : snax_csr_rsp_bits_data_i;

  always_comb begin
    snax_pvalid_o        = '0;
    snax_csr_rsp_ready_o = 1'b0;
    pop                  = 1'b0;
    if (!rst_i) begin
      if (empty) begin
        snax_csr_rsp_ready_o = 1'b1;
      end else if (head_err) begin
        snax_pvalid_o[head_port] = 1'b1;
        pop                      = snax_pready_i[head_port];
      end else begin
        snax_pvalid_o[head_port] = snax_csr_rsp_valid_i;
        snax_csr_rsp_ready_o     = snax_pready_i[head_port];
        pop                      = snax_csr_rsp_valid_i && snax_pready_i[head_port];
      end
    end
  end

  assign snax_rsp_data_o  = {NumPorts{rsp_data}};
  assign snax_rsp_id_o    = {NumPorts{head_id}};
  assign snax_rsp_error_o = {NumPorts{head_err}};
  assign outstanding_o    = count_q;
  assign proto_err_o      = proto_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arb_q       <= ArbFree;
      lock_port_q <= '0;
      rr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      arb_q       <= (snax_csr_req_valid_o && !snax_csr_req_ready_i) ? ArbLocked : ArbFree;
      lock_port_q <= grant;
      if (q_fire) rr_q <= (grant == PortW'(NumPorts - 1)) ? '0 : grant + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (empty && snax_csr_rsp_valid_i) proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      fifo_port_q[wr_ptr_q] <= grant;
      fifo_id_q[wr_ptr_q]   <= id_g;
      fifo_err_q[wr_ptr_q]  <= !in_range;
    end
  end

endmodule

// File: tb/tb_snax_csr_mux_translator.sv
// Self-checking bench: directed scenarios with literal expectations, then a randomized
// phase checked every cycle against a queue-based behavioural model.
module tb_snax_csr_mux_translator;
  localparam int NP = 2, DW = 32, AW = 32, IW = 5, NO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP*32-1:0] op, argb;
  logic [NP*DW-1:0] arga;
  logic [NP*IW-1:0] rid;
  logic [NP-1:0]    qvalid, qready, pvalid, pready, rsp_err;
  logic [NP*DW-1:0] rsp_data;
  logic [NP*IW-1:0] rsp_id;
  logic [DW-1:0]    creq_data, crsp_data;
  logic [AW-1:0]    creq_addr;
  logic             creq_write, creq_valid, creq_ready, crsp_valid, crsp_ready, proto_err;
  logic [2:0]       outstanding;

  always #5 clk = ~clk;

  snax_csr_mux_translator #(
    .NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW),
    .NumOutstanding(NO), .CsrAddrOffset(32'h3c0), .NumCsr(64)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .snax_req_data_op_i(op), .snax_req_data_arga_i(arga), .snax_req_data_argb_i(argb),
    .snax_req_id_i(rid), .snax_qvalid_i(qvalid), .snax_qready_o(qready),
    .snax_rsp_data_o(rsp_data), .snax_rsp_id_o(rsp_id), .snax_rsp_error_o(rsp_err),
    .snax_pvalid_o(pvalid), .snax_pready_i(pready),
    .snax_csr_req_bits_data_o(creq_data), .snax_csr_req_bits_addr_o(creq_addr),
    .snax_csr_req_bits_write_o(creq_write), .snax_csr_req_valid_o(creq_valid),
    .snax_csr_req_ready_i(creq_ready),
    .snax_csr_rsp_bits_data_i(crsp_data), .snax_csr_rsp_valid_i(crsp_valid),
    .snax_csr_rsp_ready_o(crsp_ready),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int port; int id; bit err; } ent_t;
  ent_t mq[$];
  int   m_rr = 0, m_lock_port = 0;
  bit   m_lock = 0, m_perr = 0;

  logic [NP-1:0] obs_qready;
  bit            obs_rd_acc, obs_rsp_hs;

  int            e_g;
  bit            e_any, e_rd, e_inr, e_full, e_cv, e_fire, e_pop, e_crdy, e_was_empty;
  logic [31:0]   e_op, e_argb;
  longint        e_a;
  logic [NP-1:0] e_qready, e_pvalid;
  ent_t          e_h;

  always @(negedge clk) begin
    #2;
    e_any = 0; e_g = 0;
    if (m_lock) begin
      e_g = m_lock_port; e_any = qvalid[e_g];
    end else begin
      for (int i = 0; i < NP; i++)
        if (!e_any && qvalid[(m_rr + i) % NP]) begin e_any = 1; e_g = (m_rr + i) % NP; end
    end
    e_op   = op[e_g*32 +: 32];
    e_argb = argb[e_g*32 +: 32];
    e_a    = longint'(e_argb);
    e_rd   = (e_op[6:0] == 7'h73) && (e_op[14:12] inside {3'd2, 3'd3, 3'd6, 3'd7});
    e_inr  = (e_a >= 960) && (e_a - 960 < 64);
    e_full = (mq.size() == NO);
    e_cv   = !rst && e_any && e_inr && (!e_rd || !e_full);
    e_fire = !rst && e_any && (e_inr ? (e_cv && creq_ready) : (!e_rd || !e_full));
    e_qready = '0;
    if (e_fire) e_qready[e_g] = 1'b1;

    e_pvalid = '0; e_crdy = 0; e_pop = 0;
    if (!rst) begin
      if (mq.size() == 0) e_crdy = 1;
      else begin
        e_h = mq[0];
        if (e_h.err) begin e_pvalid[e_h.port] = 1'b1; e_pop = pready[e_h.port]; end
        else begin
          e_pvalid[e_h.port] = crsp_valid;
          e_crdy = pready[e_h.port];
          e_pop  = crsp_valid && pready[e_h.port];
        end
      end
    end

    chk("qready", 64'(qready), 64'(e_qready));
    chk("csr_req_valid", 64'(creq_valid), 64'(e_cv));
    if (e_cv) begin
      chk("csr_req_addr", 64'(creq_addr), 64'(e_a - 960));
      chk("csr_req_data", 64'(creq_data), 64'(arga[e_g*DW +: DW]));
      chk("csr_req_write", 64'(creq_write), 64'(!e_rd));
    end
    chk("pvalid", 64'(pvalid), 64'(e_pvalid));
    chk("csr_rsp_ready", 64'(crsp_ready), 64'(e_crdy));
    if (e_pvalid != 0) begin
      chk("rsp_id", 64'(rsp_id[e_h.port*IW +: IW]), 64'(e_h.id));
      chk("rsp_error", 64'(rsp_err[e_h.port]), 64'(e_h.err));
      chk("rsp_data", 64'(rsp_data[e_h.port*DW +: DW]), e_h.err ? 64'd0 : 64'(crsp_data));
    end
    chk("outstanding", 64'(outstanding), 64'(mq.size()));
    chk("proto_err", 64'(proto_err), 64'(m_perr));

    obs_qready = qready;
    obs_rd_acc = creq_valid && creq_ready && !creq_write;
    obs_rsp_hs = crsp_valid && crsp_ready;

    if (rst) begin
      mq.delete(); m_rr = 0; m_lock = 0; m_lock_port = 0; m_perr = 0;
    end else begin
      e_was_empty = (mq.size() == 0);
      if (e_fire) m_rr = (e_g + 1) % NP;
      m_lock = e_cv && !creq_ready;
      m_lock_port = e_g;
      if (e_pop) void'(mq.pop_front());
      if (e_fire && e_rd) mq.push_back('{port: e_g, id: int'(rid[e_g*IW +: IW]), err: !e_inr});
      if (e_was_empty && crsp_valid) m_perr = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    qvalid = '0; pready = '1; creq_ready = 1'b1; crsp_valid = 1'b0; crsp_data = '0;
  endtask

  task automatic set_req(input int p, input int f3, input logic [31:0] csr,
                         input logic [31:0] a, input int id);
    op[p*32 +: 32]   = {csr[11:0], 5'd1, 3'(f3), 5'd2, 7'h73};
    argb[p*32 +: 32] = csr;
    arga[p*DW +: DW] = a;
    rid[p*IW +: IW]  = 5'(id);
    qvalid[p]        = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] csr;
    int          f3;
    case ($urandom_range(0, 5))
      0, 1, 2: csr = 32'h3c0 + $urandom_range(0, 63);
      3:       begin
                 logic [31:0] edges [4] = '{32'h3bf, 32'h400, 32'h3ff, 32'h3c0};
                 csr = edges[$urandom_range(0, 3)];
               end
      4:       csr = $urandom;
      default: csr = 32'h100;
    endcase
    f3 = $urandom_range(0, 7);
    set_req(p, f3, csr, $urandom, $urandom_range(0, 31));
    if ($urandom_range(0, 9) == 0) op[p*32 +: 7] = 7'h33;
    qvalid[p] = 1'b0;
  endtask

  int pending = 0;

  initial begin
    op = '0; argb = '0; arga = '0; rid = '0;
    rst = 1'b1; idle();

    // reset holds every handshake low even with requests and a response offered
    step(); set_req(0, 2, 32'h3c1, 0, 1); set_req(1, 1, 32'h3c2, 0, 2); crsp_valid = 1'b1;
    #3; chk("rst_qready", 64'(qready), 0); chk("rst_csr_req_valid", 64'(creq_valid), 0);
    chk("rst_pvalid", 64'(pvalid), 0); chk("rst_csr_rsp_ready", 64'(crsp_ready), 0);
    step(); rst = 1'b0; idle();
    #3; chk("init_outstanding", 64'(outstanding), 0); chk("init_proto_err", 64'(proto_err), 0);

    // port 0 writes CSR 0x3c5
    step(); set_req(0, 1, 32'h3c5, 32'hDEAD_BEEF, 1);
    #3; chk("wr_valid", 64'(creq_valid), 1); chk("wr_addr", 64'(creq_addr), 5);
    chk("wr_write", 64'(creq_write), 1); chk("wr_data", 64'(creq_data), 64'hDEADBEEF);
    chk("wr_qready", 64'(qready), 1); chk("wr_pvalid", 64'(pvalid), 0);
    step(); idle();

    // both ports read, FIFO fills, responses return in order
    do_reset();
    set_req(0, 2, 32'h3c1, 0, 3); set_req(1, 2, 32'h3c2, 0, 7);
    #3; chk("rr0", 64'(qready), 1);
    step(); #3; chk("rr1", 64'(qready), 2);
    step(); #3; chk("rr2", 64'(qready), 1);
    step(); #3; chk("rr3", 64'(qready), 2);
    step(); #3; chk("full_qready", 64'(qready), 0); chk("full_valid", 64'(creq_valid), 0);
    chk("full_outstanding", 64'(outstanding), 4);
    step(); crsp_valid = 1'b1; crsp_data = 32'hA;
    #3; chk("rspA_pvalid", 64'(pvalid), 1); chk("rspA_data", 64'(rsp_data[31:0]), 64'hA);
    chk("rspA_id", 64'(rsp_id[4:0]), 3); chk("rspA_qready", 64'(qready), 0);
    step(); crsp_data = 32'hB;
    #3; chk("after_pop_outstanding", 64'(outstanding), 3); chk("fifth_qready", 64'(qready), 1);
    chk("rspB_pvalid", 64'(pvalid), 2); chk("rspB_id", 64'(rsp_id[9:5]), 7);
    chk("rspB_data", 64'(rsp_data[63:32]), 64'hB);
    step(); qvalid = '0; crsp_data = 32'hC;
    step(); crsp_data = 32'hD;
    step(); crsp_data = 32'hE;
    step(); crsp_valid = 1'b0;
    #3; chk("drained", 64'(outstanding), 0);

    // out-of-range read queued behind an in-range read
    do_reset();
    set_req(0, 2, 32'h3c1, 0, 4);
    #3; chk("oor_pre_valid", 64'(creq_valid), 1);
    step(); qvalid = '0; set_req(1, 2, 32'h100, 0, 9);
    #3; chk("oor_qready", 64'(qready), 2); chk("oor_no_csr_req", 64'(creq_valid), 0);
    step(); qvalid = '0;
    #3; chk("oor_wait_pvalid", 64'(pvalid), 0);
    step(); crsp_valid = 1'b1; crsp_data = 32'h55;
    #3; chk("oor_p0_pvalid", 64'(pvalid), 1); chk("oor_p0_data", 64'(rsp_data[31:0]), 64'h55);
    step(); crsp_valid = 1'b0;
    #3; chk("oor_p1_pvalid", 64'(pvalid), 2); chk("oor_p1_err", 64'(rsp_err[1]), 1);
    chk("oor_p1_data", 64'(rsp_data[63:32]), 0); chk("oor_p1_id", 64'(rsp_id[9:5]), 9);
    step(); #3; chk("oor_drained", 64'(outstanding), 0);

    // grant stays locked on a stalled port 0 request even though rr favours port 1
    do_reset();
    set_req(0, 1, 32'h3c0, 32'h11, 1);
    step(); set_req(0, 1, 32'h3c3, 32'h22, 2); creq_ready = 1'b0;
    #3; chk("lock_qready0", 64'(qready), 0); chk("lock_addr0", 64'(creq_addr), 3);
    step(); set_req(1, 1, 32'h3c4, 32'h33, 3);
    #3; chk("lock_qready1", 64'(qready), 0); chk("lock_addr1", 64'(creq_addr), 3);
    step(); #3; chk("lock_addr2", 64'(creq_addr), 3);
    step(); creq_ready = 1'b1;
    #3; chk("lock_release", 64'(qready), 1); chk("lock_addr3", 64'(creq_addr), 3);
    step(); qvalid[0] = 1'b0;
    #3; chk("lock_next", 64'(qready), 2); chk("lock_next_addr", 64'(creq_addr), 4);
    step(); idle();

    // response with empty FIFO sets the sticky flag; only reset clears it
    do_reset();
    crsp_valid = 1'b1;
    #3; chk("drain_ready", 64'(crsp_ready), 1);
    step(); crsp_valid = 1'b0;
    #3; chk("perr_set", 64'(proto_err), 1);
    step(); step(); #3; chk("perr_sticky", 64'(proto_err), 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    #3; chk("perr_cleared", 64'(proto_err), 0); chk("perr_outstanding", 64'(outstanding), 0);

    // randomized traffic with occasional mid-transaction resets
    pending = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = 1'b0;
      for (int p = 0; p < NP; p++)
        if (!qvalid[p] || obs_qready[p]) begin
          rand_req(p);
          qvalid[p] = ($urandom_range(0, 99) < 65);
        end
      creq_ready = ($urandom_range(0, 99) < 70);
      pready     = 2'($urandom_range(0, 3));
      if (crsp_valid && obs_rsp_hs) pending--;
      if (obs_rd_acc) pending++;
      if (!(crsp_valid && !obs_rsp_hs)) begin
        crsp_valid = (pending > 0) && ($urandom_range(0, 99) < 60);
        crsp_data  = $urandom;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; pending = 0; crsp_valid = 1'b0;
      end
    end
    step(); idle();
    step();
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
